// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_SRA = 3'b111
  } alu_op_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {C,V,N,Z} flags from (a, b, opcode).
// Flag logic is built only when ALU_PIPE_FLAGS_EN is defined; otherwise flags are 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          opcode,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    result = '0;
    case (opcode)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SHL: result = a << shamt;
      ALU_SHR: result = a >> shamt;
      ALU_SRA: result = WIDTH'($signed(a) >>> shamt);
      default: result = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  always_comb begin
    flags = '0;
    case (opcode)
      ALU_ADD: begin
        // A wrapped sum is smaller than either addend exactly when bit WIDTH carried out.
        flags[FLAG_C] = (result < a);
        flags[FLAG_V] = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        flags[FLAG_C] = (a < b);
        flags[FLAG_V] = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == '0);
  end
`else
  assign flags = 4'b0000;
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU: S1 registers operands, S2 registers result and flags.
// Optional flag generation via ALU_PIPE_FLAGS_EN (flags read 0 when undefined).
module alu_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic             v1, v2;
  logic             s1_ready, s2_ready;
  logic [WIDTH-1:0] a1, b1;
  alu_op_e          op1;
  logic [WIDTH-1:0] core_result, res2;
  logic [3:0]       core_flags, flags2;

  // A stage can take a new beat when it is empty or its contents move on this cycle.
  assign s2_ready = !v2 || out_ready;
  assign s1_ready = !v1 || s2_ready;
  assign in_ready = s1_ready;

  // NOTE: data registers are reset too, because result/flags must read 0 during reset.
  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      op1 <= ALU_ADD;
    end else if (s1_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1  <= a;
        b1  <= b;
        op1 <= alu_op_e'(opcode);
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a      (a1),
    .b      (b1),
    .opcode (op1),
    .result (core_result),
    .flags  (core_flags)
  );

  // Result/flags only load when a beat moves in, so they hold steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2     <= 1'b0;
      res2   <= '0;
      flags2 <= '0;
    end else if (s2_ready) begin
      v2 <= v1;
      if (v1) begin
        res2   <= core_result;
        flags2 <= core_flags;
      end
    end
  end

  assign out_valid = v2;
  assign result    = res2;
  assign flags     = flags2;

endmodule
